// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM stage of the RV32I pipeline.
//   - mem_read_e  : load type encoding carried on ex_memread
//   - mem_write_e : store type encoding carried on ex_memwrite
//   - mem_state_e : MEM stage access FSM states
//   - mem_misaligned() : natural-alignment check for an access, used when
//     MEM_MISALIGN_TRAP_EN is defined
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [2:0] {
    MR_NONE = 3'b000,
    MR_LB   = 3'b001,
    MR_LH   = 3'b010,
    MR_LW   = 3'b011,
    MR_LBU  = 3'b100,
    MR_LHU  = 3'b101
  } mem_read_e;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SB   = 2'b01,
    MW_SH   = 2'b10,
    MW_SW   = 2'b11
  } mem_write_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  // True when the access is not naturally aligned. A store type wins over a
  // load type because an instruction carrying both is executed as a store.
  function automatic logic mem_misaligned(input logic [1:0] addr_lo,
                                          input logic [2:0] mr,
                                          input logic [1:0] mw);
    logic bad;
    bad = 1'b0;
    if (mw != MW_NONE) begin
      if (mw == MW_SH) bad = addr_lo[0];
      if (mw == MW_SW) bad = (addr_lo != 2'b00);
    end else begin
      if (mr == MR_LH || mr == MR_LHU) bad = addr_lo[0];
      if (mr == MR_LW)                 bad = (addr_lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational lane logic for the MEM stage.
//   Store side: replicates store data onto every lane the access may hit and
//   produces the byte enables for the addressed lanes.
//   Load side: picks the addressed byte/half out of the returned word and
//   sign- or zero-extends it to 32 bits.
// Ports
//   st_addr_lo [1:0]  in   low address bits of the store
//   st_type    [1:0]  in   store type (mem_write_e encoding)
//   st_data    [31:0] in   raw store data (rs2)
//   st_be      [3:0]  out  byte enables (0000 when st_type is NONE)
//   st_lanes   [31:0] out  lane-steered store data
//   ld_addr_lo [1:0]  in   low address bits of the load
//   ld_type    [2:0]  in   load type (mem_read_e encoding)
//   ld_word    [31:0] in   word returned by D-Mem
//   ld_data    [31:0] out  extracted and extended load value
// -----------------------------------------------------------------------------
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store steering: data is replicated so the memory only needs the enables.
  always_comb begin
    st_be    = 4'b0000;
    st_lanes = st_data;
    case (st_type)
      MW_SB: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_lanes = {4{st_data[7:0]}};
      end
      MW_SH: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      MW_SW: begin
        st_be    = 4'b1111;
        st_lanes = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_lanes = st_data;
      end
    endcase
  end

  // Load extraction: bit 0 is ignored for halves, both bits for words.
  always_comb begin
    ld_byte = ld_word[7:0];
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_word[7:0];
      2'b01:   ld_byte = ld_word[15:8];
      2'b10:   ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    ld_data = ld_word;
    case (ld_type)
      MR_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MR_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      MR_LW:   ld_data = ld_word;
      MR_LBU:  ld_data = {24'h0, ld_byte};
      MR_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage RV32I pipeline. Takes the EX/MEM register contents,
// runs loads/stores against D-Mem and drives the registered MEM/WB slot.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW never reach D-Mem; bus_err pulses
//               the cycle after detection and MEM/WB bubbles.
//   undefined : low address bits are simply ignored for alignment.
//
// Parameters
//   TIMEOUT_CYC  BUSY cycles to wait for dm_ready before a bus error (0 = never)
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid .. ex_memtoreg   EX/MEM register contents
//   mem_stall          out    hold upstream registers; ex_* stay stable while high
//   dm_req/we/addr/be/wdata   D-Mem request
//   dm_ready, dm_rdata  in    D-Mem completion and load word
//   wb_valid/rd/regwrite/data MEM/WB register
//   bus_err            out    one-cycle pulse on timeout or misaligned trap
//   dbg_state          out    current FSM state
//
// D-Mem handshake: dm_req is held high with all dm_* request fields stable
// from the first BUSY cycle until the cycle in which dm_ready is high. The
// request completes in exactly that cycle and dm_rdata is sampled in it;
// dm_ready while dm_req is low is ignored.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_memread,
  input  logic [1:0]  ex_memwrite,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output mem_state_e  dbg_state
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYC == 0) ? 0 : (TIMEOUT_CYC - 1));

  mem_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    ld_type_q;
  logic [4:0]    rd_q;
  logic          regwrite_q;
  logic          memtoreg_q;

  logic        is_store;
  logic        is_load;
  logic        memop;
  logic        trap;
  logic        timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_lanes;
  logic [31:0] ld_data;

  assign is_store = (ex_memwrite != MW_NONE);
  assign is_load  = (ex_memread != MR_NONE);
  assign memop    = ex_valid & (is_store | is_load);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = memop & mem_misaligned(ex_aluout[1:0], ex_memread, ex_memwrite);
`else
  assign trap = 1'b0;
`endif

  // The counter value is the number of BUSY cycles already completed, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYC-1.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  mem_align u_align (
    .st_addr_lo (ex_aluout[1:0]),
    .st_type    (ex_memwrite),
    .st_data    (ex_wdata),
    .st_be      (st_be),
    .st_lanes   (st_lanes),
    .ld_addr_lo (addr_q[1:0]),
    .ld_type    (ld_type_q),
    .ld_word    (dm_rdata),
    .ld_data    (ld_data)
  );

  // A fault (timeout or trap) leaves the faulting instruction held in EX/MEM
  // because mem_stall was high in the cycle that raised it. While bus_err is
  // high that held instruction is dropped: no stall, no issue, bubble in WB.
  assign mem_stall = ~bus_err &
                     (((state_q == IDLE) & memop) |
                      ((state_q == BUSY) & ~dm_ready));

  assign dm_req    = (state_q == BUSY);
  assign dm_we     = we_q;
  assign dm_addr   = {addr_q[31:2], 2'b00};
  assign dm_be     = be_q;
  assign dm_wdata  = wdata_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ld_type_q   <= MR_NONE;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      wb_data     <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_err) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else if (trap) begin
            bus_err     <= 1'b1;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else if (memop) begin
            addr_q      <= ex_aluout;
            be_q        <= is_store ? st_be : 4'b1111;
            wdata_q     <= st_lanes;
            we_q        <= is_store;
            ld_type_q   <= ex_memread;
            rd_q        <= ex_rd;
            regwrite_q  <= ex_regwrite;
            memtoreg_q  <= ex_memtoreg;
            cnt_q       <= '0;
            state_q     <= BUSY;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
          end else begin
            wb_valid    <= ex_valid;
            wb_rd       <= ex_rd;
            wb_regwrite <= ex_regwrite & ex_valid;
            wb_data     <= ex_aluout;
          end
        end
        BUSY: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (dm_ready) begin
            wb_valid    <= 1'b1;
            wb_rd       <= rd_q;
            wb_regwrite <= regwrite_q & ~we_q;
            wb_data     <= (~we_q & memtoreg_q) ? ld_data : addr_q;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            bus_err     <= 1'b1;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            state_q     <= IDLE;
          end else begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            if (TIMEOUT_CYC != 0) cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
